rom_fetch_unit: RTL

Instruction-fetch initiator for the MCU's synchronous program ROM. Drives the ROM address bus from a program counter and captures the returned byte one cycle later. Buffers fetched bytes with their addresses in a small prefetch FIFO and presents them to the instruction decoder over a valid/ready handshake. Supports jump redirects, which flush all buffered and in-flight fetches.

---
 rtl/mcu_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 86 ++++++++
 rtl/rom_fetch_unit.sv | 108 ++++++++++
 3 files changed

// File: rtl/mcu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mcu_pkg
//  Description : Shared MCU definitions used by the program ROM, the fetch
//                unit and the instruction decoder. It holds the ROM bus
//                widths, the reset vector and the fetch-entry record
//                {addr, data}.
//  Revision    : 1.0 - initial release
// ============================================================================
package mcu_pkg;

    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 8;
    localparam logic [ADDR_WIDTH-1:0] RESET_VECTOR = 8'h00;

    // One fetched byte together with the ROM address it was read from.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } fetch_entry_t;

endpackage : mcu_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Synchronous prefetch FIFO of fetch entries. It supports
//                push, pop and flush, and reports its occupancy. A push and
//                a pop in the same cycle are legal at any occupancy,
//                including full. A flush wins over everything else.
//  Ports       : clk          - clock, rising edge
//                rst_n        - asynchronous active-low reset
//                i_push       - write i_push_data at the tail
//                i_push_data  - entry to write
//                i_pop        - advance past the head entry
//                i_flush      - discard all entries
//                o_head       - head entry (stale storage when empty)
//                o_valid      - FIFO non-empty
//                o_count      - number of stored entries
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int  DEPTH   = 4,
    parameter type ENTRY_T = mcu_pkg::fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  ENTRY_T                   i_push_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output ENTRY_T                   o_head,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    ENTRY_T               r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_cnt_w-1:0]   r_count;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_cnt_w'(DEPTH));
    assign w_do_pop  = i_pop && !w_empty;
    // A push into a full FIFO is only safe when the head leaves at the same edge.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_valid = !w_empty;
    assign o_count = r_count;

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/rom_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : rom_fetch_unit
//  Description : Instruction-fetch initiator for the synchronous program ROM.
//                It drives the ROM address from the PC, captures the byte
//                returned one cycle later into a prefetch FIFO, and hands
//                bytes to the decoder over a valid/ready handshake. A JUMP
//                redirects the PC and flushes buffered and in-flight fetches.
//  Ports       : CLK          - system clock, rising edge
//                RESETn       - asynchronous active-low reset
//                ROM_ADDR     - ROM address (the PC register)
//                ROM_DATA     - ROM read data, one cycle after the address
//                INSTR        - FIFO head byte
//                INSTR_ADDR   - address of the FIFO head byte
//                INSTR_VALID  - FIFO non-empty
//                INSTR_READY  - decoder accepts the head this cycle
//                JUMP         - one-cycle redirect strobe
//                JUMP_ADDR    - redirect target
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_fetch_unit #(
    parameter int                    ADDR_WIDTH   = mcu_pkg::ADDR_WIDTH,
    parameter int                    DATA_WIDTH   = mcu_pkg::DATA_WIDTH,
    parameter int                    FIFO_DEPTH   = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(mcu_pkg::RESET_VECTOR)
) (
    input  logic                  CLK,
    input  logic                  RESETn,
    output logic [ADDR_WIDTH-1:0] ROM_ADDR,
    input  logic [DATA_WIDTH-1:0] ROM_DATA,
    output logic [DATA_WIDTH-1:0] INSTR,
    output logic [ADDR_WIDTH-1:0] INSTR_ADDR,
    output logic                  INSTR_VALID,
    input  logic                  INSTR_READY,
    input  logic                  JUMP,
    input  logic [ADDR_WIDTH-1:0] JUMP_ADDR
);

    localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;

    // Same layout as mcu_pkg::fetch_entry_t, sized from this instance's parameters.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_pending;
    logic [ADDR_WIDTH-1:0] r_pend_addr;

    logic [c_cnt_w-1:0]    w_count;
    logic [c_cnt_w-1:0]    w_inflight;
    logic                  w_issue;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_valid;
    entry_t                w_push_entry;
    entry_t                w_head;

    // Buffered plus in-flight bytes must never exceed the FIFO capacity, so
    // a fetch is only issued when its data is guaranteed a slot on arrival.
    assign w_inflight   = w_count + c_cnt_w'(r_pending);
    assign w_issue      = !JUMP && (w_inflight < c_cnt_w'(FIFO_DEPTH));
    assign w_push       = r_pending && !JUMP;
    assign w_pop        = w_valid && INSTR_READY && !JUMP;
    assign w_push_entry = {r_pend_addr, ROM_DATA};

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_pc        <= RESET_VECTOR;
            r_pending   <= 1'b0;
            r_pend_addr <= '0;
        end else if (JUMP) begin
            // The byte returned next cycle belongs to the old stream; dropping
            // the pending flag discards it.
            r_pc      <= JUMP_ADDR;
            r_pending <= 1'b0;
        end else if (w_issue) begin
            r_pc        <= r_pc + ADDR_WIDTH'(1);
            r_pending   <= 1'b1;
            r_pend_addr <= r_pc;
        end else begin
            r_pending <= 1'b0;
        end
    end

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .ENTRY_T (entry_t)
    ) u_fifo (
        .clk         (CLK),
        .rst_n       (RESETn),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .i_flush     (JUMP),
        .o_head      (w_head),
        .o_valid     (w_valid),
        .o_count     (w_count)
    );

    assign ROM_ADDR    = r_pc;
    assign INSTR       = w_head.data;
    assign INSTR_ADDR  = w_head.addr;
    assign INSTR_VALID = w_valid;

endmodule : rom_fetch_unit
`default_nettype wire
